// File: rtl/top_level_pkg.sv
// Shared definitions for the top_level 8-bit accumulator/register core:
// datapath widths, the 3-bit major opcode, SYS sub-ops and write-back select.
package top_level_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned PC_W    = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_XOR = 3'd1,
    OP_AND = 3'd2,
    OP_SHL = 3'd3,
    OP_SHR = 3'd4,
    OP_LD  = 3'd5,
    OP_ST  = 3'd6,
    OP_SYS = 3'd7
  } opcode_e;

  // Sub-op carried in Instruction[5:4] when the major opcode is OP_SYS.
  typedef enum logic [1:0] {
    SYS_LI   = 2'd0,
    SYS_CEQ  = 2'd1,
    SYS_BEQ  = 2'd2,
    SYS_MISC = 2'd3
  } sysop_e;

  // SYS_MISC with this low nibble halts; every other nibble is a NOP.
  localparam logic [3:0] HALT_CODE = 4'b1111;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_IMM = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/top_level_alu.sv
// alu: combinational datapath of the core.
//   ALU_op_code : major opcode (Instruction[8:6])
//   ALU_arg_0   : R[rd] operand      ALU_arg_1 : R[rs] operand
//   ALU_shamt   : imm3 shift amount  ALU_out   : 8-bit result (carries dropped)
//   ALU_eq      : ALU_arg_0 == ALU_arg_1
// Non-arithmetic opcodes pass ALU_arg_0 through.
module alu
  import top_level_pkg::*;
(
  input  logic [2:0]        ALU_op_code,
  input  logic [DATA_W-1:0] ALU_arg_0,
  input  logic [DATA_W-1:0] ALU_arg_1,
  input  logic [2:0]        ALU_shamt,
  output logic [DATA_W-1:0] ALU_out,
  output logic              ALU_eq
);

  always_comb begin
    ALU_out = ALU_arg_0;
    case (opcode_e'(ALU_op_code))
      OP_ADD:  ALU_out = ALU_arg_0 + ALU_arg_1;
      OP_XOR:  ALU_out = ALU_arg_0 ^ ALU_arg_1;
      OP_AND:  ALU_out = ALU_arg_0 & ALU_arg_1;
      OP_SHL:  ALU_out = ALU_arg_0 << ALU_shamt;
      OP_SHR:  ALU_out = ALU_arg_0 >> ALU_shamt;
      default: ALU_out = ALU_arg_0;
    endcase
  end

  assign ALU_eq = (ALU_arg_0 == ALU_arg_1);

endmodule

// File: rtl/top_level.sv
// top_level: single-cycle 8-bit register processor (CSE141L top).
// Executes one 9-bit instruction per CLK from an internal ROM against an
// 8x8 register file and a 256x8 data memory.
//   CLK   : sole clock, all state updates on the rising edge
//   start : asynchronous active-high reset of PC, EQUAL and halt only
//   halt  : 1 once HALT has executed, held until start
// The instruction image is placed in instr_rom1.core by the program loader.

// pc: program counter. hold_i freezes it, branch_i loads target_i.
module pc
  import top_level_pkg::*;
(
  input  logic            CLK,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            branch_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] PC
);

  logic [PC_W-1:0] pc_d;

  always_comb pc_d = branch_i ? target_i : PC + 8'd1;

  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i)        PC <= '0;
    else if (!hold_i) PC <= pc_d;
  end

endmodule

// ctrl: instruction decoder. All side effects are suppressed while the core
// is halted or held in reset, so register/memory contents survive start.
module ctrl
  import top_level_pkg::*;
(
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               halt_i,
  input  logic               rst_i,
  output logic [REG_AW-1:0]  Reg_read_address_0,
  output logic [REG_AW-1:0]  Reg_read_address_1,
  output logic [2:0]         alu_op_o,
  output logic               reg_we_o,
  output logic [REG_AW-1:0]  reg_waddr_o,
  output wb_sel_e            wb_sel_o,
  output logic               mem_we_o,
  output logic               ceq_o,
  output logic               beq_o,
  output logic               halt_o
);

  opcode_e op;
  assign op       = opcode_e'(Instruction[8:6]);
  assign alu_op_o = Instruction[8:6];

  always_comb begin
    Reg_read_address_0 = Instruction[5:3];
    Reg_read_address_1 = Instruction[2:0];
    reg_we_o           = 1'b0;
    reg_waddr_o        = Instruction[5:3];
    wb_sel_o           = WB_ALU;
    mem_we_o           = 1'b0;
    ceq_o              = 1'b0;
    beq_o              = 1'b0;
    halt_o             = 1'b0;
    case (op)
      OP_ADD, OP_XOR, OP_AND, OP_SHL, OP_SHR: reg_we_o = 1'b1;
      OP_LD: begin
        reg_we_o = 1'b1;
        wb_sel_o = WB_MEM;
      end
      OP_ST: mem_we_o = 1'b1;
      OP_SYS: begin
        // SYS ops have no rd field; port 0 reads R0 so the ALU equality
        // output directly gives R0 == R[rs] for CEQ.
        Reg_read_address_0 = '0;
        case (sysop_e'(Instruction[5:4]))
          SYS_LI: begin
            reg_we_o    = 1'b1;
            reg_waddr_o = '0;
            wb_sel_o    = WB_IMM;
          end
          SYS_CEQ:  ceq_o  = 1'b1;
          SYS_BEQ:  beq_o  = 1'b1;
          SYS_MISC: halt_o = (Instruction[3:0] == HALT_CODE);
          default:  ;
        endcase
      end
      default: ;
    endcase
    if (halt_i || rst_i) begin
      reg_we_o = 1'b0;
      mem_we_o = 1'b0;
      ceq_o    = 1'b0;
      beq_o    = 1'b0;
      halt_o   = 1'b0;
    end
  end

endmodule

// reg_file: 8x8 registers, two combinational read ports, one write port.
module reg_file
  import top_level_pkg::*;
(
  input  logic              CLK,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr0_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);

  logic [DATA_W-1:0] registers [0:7];

  assign rdata0_o = registers[raddr0_i];
  assign rdata1_o = registers[raddr1_i];

  always_ff @(posedge CLK) begin
    if (we_i) registers[waddr_i] <= wdata_i;
  end

endmodule

// data_mem: 256x8 data memory, combinational read, clocked write.
module data_mem
  import top_level_pkg::*;
(
  input  logic              CLK,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] core [0:255];

  assign rdata_o = core[addr_i];

  always_ff @(posedge CLK) begin
    if (we_i) core[addr_i] <= wdata_i;
  end

endmodule

// instr_rom: combinational instruction ROM indexed by the PC.
module instr_rom
  import top_level_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 256
) (
  input  logic [PC_W-1:0]    addr_i,
  output logic [INSTR_W-1:0] instr_o
);

  logic [INSTR_W-1:0] core [0:ROM_DEPTH-1];

  assign instr_o = core[addr_i];

endmodule

module top_level
  import top_level_pkg::*;
#(
  parameter string       ROM_FILE  = "machine_code.txt",
  parameter int unsigned ROM_DEPTH = 256
) (
  input  logic CLK,
  input  logic start,
  output logic halt
);

  logic [PC_W-1:0]    PC;
  logic [INSTR_W-1:0] Instruction;
  logic               EQUAL;
  logic               halt_q;

  logic [REG_AW-1:0]  raddr0, raddr1, waddr;
  logic [DATA_W-1:0]  rdata0, rdata1, alu_out, mem_rdata, wdata;
  logic [2:0]         alu_op;
  logic               reg_we, mem_we, ceq, beq, halt_exec, alu_eq;
  wb_sel_e            wb_sel;

  instr_rom #(.ROM_DEPTH(ROM_DEPTH)) instr_rom1 (
    .addr_i (PC),
    .instr_o(Instruction)
  );

  ctrl Ctrl1 (
    .Instruction       (Instruction),
    .halt_i            (halt_q),
    .rst_i             (start),
    .Reg_read_address_0(raddr0),
    .Reg_read_address_1(raddr1),
    .alu_op_o          (alu_op),
    .reg_we_o          (reg_we),
    .reg_waddr_o       (waddr),
    .wb_sel_o          (wb_sel),
    .mem_we_o          (mem_we),
    .ceq_o             (ceq),
    .beq_o             (beq),
    .halt_o            (halt_exec)
  );

  reg_file reg_file1 (
    .CLK     (CLK),
    .we_i    (reg_we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr0_i(raddr0),
    .raddr1_i(raddr1),
    .rdata0_o(rdata0),
    .rdata1_o(rdata1)
  );

  alu ALU1 (
    .ALU_op_code(alu_op),
    .ALU_arg_0  (rdata0),
    .ALU_arg_1  (rdata1),
    .ALU_shamt  (Instruction[2:0]),
    .ALU_out    (alu_out),
    .ALU_eq     (alu_eq)
  );

  data_mem data_mem1 (
    .CLK    (CLK),
    .we_i   (mem_we),
    .addr_i (rdata1),
    .wdata_i(rdata0),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    case (wb_sel)
      WB_MEM:  wdata = mem_rdata;
      WB_IMM:  wdata = {4'b0000, Instruction[3:0]};
      default: wdata = alu_out;
    endcase
  end

  // PC freezes on the HALT edge itself as well as afterwards.
  pc PC1 (
    .CLK     (CLK),
    .rst_i   (start),
    .hold_i  (halt_q || halt_exec),
    .branch_i(beq && EQUAL),
    .target_i(rdata1),
    .PC      (PC)
  );

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      EQUAL  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      if (ceq)       EQUAL  <= alu_eq;
      if (halt_exec) halt_q <= 1'b1;
    end
  end

  assign halt = halt_q;

endmodule

// File: tb/tb_top_level.sv
module tb_top_level;

  logic CLK;
  logic start;
  logic halt;

  top_level #(.ROM_DEPTH(256)) dut (
    .CLK  (CLK),
    .start(start),
    .halt (halt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Instruction-set reference model
  logic [8:0] m_rom [256];
  logic [7:0] m_reg [8];
  logic [7:0] m_mem [256];
  logic [7:0] m_pc;
  logic       m_eq;
  logic       m_halt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [8:0] NOP  = 9'b111110000;
  localparam logic [8:0] HLT  = 9'b111111111;

  function automatic void model_step();
    logic [8:0] ins;
    logic [2:0] rd, rs;
    logic [7:0] a, b, nxt;
    if (m_halt) return;
    ins = m_rom[m_pc];
    rd  = ins[5:3];
    rs  = ins[2:0];
    a   = m_reg[rd];
    b   = m_reg[rs];
    nxt = m_pc + 8'd1;
    case (ins[8:6])
      3'd0: m_reg[rd] = a + b;
      3'd1: m_reg[rd] = a ^ b;
      3'd2: m_reg[rd] = a & b;
      3'd3: m_reg[rd] = a << rs;
      3'd4: m_reg[rd] = a >> rs;
      3'd5: m_reg[rd] = m_mem[b];
      3'd6: m_mem[b]  = a;
      default: begin
        case (ins[5:4])
          2'd0: m_reg[0] = {4'h0, ins[3:0]};
          2'd1: m_eq = (m_reg[0] == b);
          2'd2: if (m_eq) nxt = b;
          default: if (ins[3:0] == 4'hF) begin
            m_halt = 1'b1;
            nxt    = m_pc;
          end
        endcase
      end
    endcase
    m_pc = nxt;
  endfunction

  function automatic logic [73:0] dut_state();
    logic [73:0] v;
    v[73:66] = dut.PC;
    v[65]    = halt;
    v[64]    = dut.EQUAL;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = dut.reg_file1.registers[i];
    return v;
  endfunction

  function automatic logic [73:0] model_state();
    logic [73:0] v;
    v[73:66] = m_pc;
    v[65]    = m_halt;
    v[64]    = m_eq;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_reg[i];
    return v;
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) m_rom[i] = NOP;
  endtask

  task automatic randomize_state();
    for (int i = 0; i < 8; i++)   m_reg[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
  endtask

  task automatic push_state();
    for (int i = 0; i < 8; i++)   dut.reg_file1.registers[i] = m_reg[i];
    for (int i = 0; i < 256; i++) dut.data_mem1.core[i] = m_mem[i];
    for (int i = 0; i < 256; i++) dut.instr_rom1.core[i] = m_rom[i];
  endtask

  task automatic begin_run();
    start = 1'b1;
    @(negedge CLK);
    push_state();
    m_pc = 8'd0; m_eq = 1'b0; m_halt = 1'b0;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_nop();
    randomize_state();
    m_reg[3] = 8'h5A;
    m_mem[7] = 8'h11;
    start = 1'b1;
    @(negedge CLK);
    push_state();
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (dut.PC !== 8'd0 || halt !== 1'b0 || dut.EQUAL !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: PC=%h halt=%b EQUAL=%b, want PC=00 halt=0 EQUAL=0", dut.PC, halt, dut.EQUAL);
    end
    start = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (dut.reg_file1.registers[3] !== 8'h5A || dut.data_mem1.core[7] !== 8'h11) begin
      n_bad++;
      $display("FAIL reset_keep: R3=%h mem7=%h, want 5a 11", dut.reg_file1.registers[3], dut.data_mem1.core[7]);
    end
    n_cmp++;
    if (dut.PC !== 8'd1 || dut.PC1.PC !== 8'd1) begin
      n_bad++;
      $display("FAIL reset_first_fetch: PC=%h PC1.PC=%h, want 01", dut.PC, dut.PC1.PC);
    end
  endtask

  task automatic test_alu();
    logic [7:0] exp_r1 [4];
    exp_r1[0] = 8'd9; exp_r1[1] = 8'd18; exp_r1[2] = 8'd72; exp_r1[3] = 8'd0;
    fill_nop();
    randomize_state();
    m_reg[1] = 8'd0;
    m_rom[0] = 9'b111001001;  // LI 9
    m_rom[1] = 9'b000001000;  // ADD R1,R0
    m_rom[2] = 9'b000001000;  // ADD R1,R0
    m_rom[3] = 9'b011001010;  // SHL R1,2
    m_rom[4] = 9'b001001001;  // XOR R1,R1
    m_rom[5] = HLT;
    begin_run();
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      model_step();
      n_cmp++;
      if (dut_state() !== model_state()) begin
        n_bad++;
        $display("FAIL alu_cycle%0d: state %h, want %h", c, dut_state(), model_state());
      end
      if (c == 0) begin
        n_cmp++;
        if (dut.Ctrl1.Reg_read_address_0 !== 3'd1 || dut.Ctrl1.Reg_read_address_1 !== 3'd0 ||
            dut.ALU1.ALU_op_code !== 3'd0 || dut.ALU1.ALU_out !== 8'(m_reg[1] + m_reg[0])) begin
          n_bad++;
          $display("FAIL alu_probe: ra0=%0d ra1=%0d op=%0d out=%h, want 1 0 0 %h",
                   dut.Ctrl1.Reg_read_address_0, dut.Ctrl1.Reg_read_address_1,
                   dut.ALU1.ALU_op_code, dut.ALU1.ALU_out, 8'(m_reg[1] + m_reg[0]));
        end
      end
      if (c >= 1 && c <= 4) begin
        n_cmp++;
        if (dut.reg_file1.registers[1] !== exp_r1[c-1]) begin
          n_bad++;
          $display("FAIL alu_r1_step%0d: R1=%0d, want %0d", c, dut.reg_file1.registers[1], exp_r1[c-1]);
        end
      end
      if (c >= 5) begin
        n_cmp++;
        if (halt !== 1'b1 || dut.PC !== 8'd5) begin
          n_bad++;
          $display("FAIL alu_halt_hold%0d: halt=%b PC=%h, want 1 05", c, halt, dut.PC);
        end
      end
    end
  endtask

  task automatic test_memory();
    int unsigned diffs;
    fill_nop();
    randomize_state();
    m_mem[4] = 8'hA7;
    m_reg[2] = 8'd4;
    m_rom[0] = 9'b101101010;  // LD R5,[R2]
    m_rom[1] = 9'b100101100;  // SHR R5,4
    m_rom[2] = 9'b110101010;  // ST R5,[R2]
    m_rom[3] = HLT;
    begin_run();
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      model_step();
      n_cmp++;
      if (dut_state() !== model_state()) begin
        n_bad++;
        $display("FAIL mem_cycle%0d: state %h, want %h", c, dut_state(), model_state());
      end
    end
    n_cmp++;
    if (dut.data_mem1.core[4] !== 8'h0A || dut.reg_file1.registers[5] !== 8'h0A) begin
      n_bad++;
      $display("FAIL mem_result: mem4=%h R5=%h, want 0a 0a", dut.data_mem1.core[4], dut.reg_file1.registers[5]);
    end
    diffs = 0;
    for (int i = 0; i < 256; i++) if (dut.data_mem1.core[i] !== m_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin
      n_bad++;
      $display("FAIL mem_image: %0d bytes differ, want 0", diffs);
    end
  endtask

  task automatic test_branch();
    fill_nop();
    randomize_state();
    m_reg[0] = 8'd3; m_reg[1] = 8'd3; m_reg[6] = 8'd10;
    m_rom[0]  = 9'b111010001;  // CEQ R1
    m_rom[1]  = 9'b111100110;  // BEQ R6
    m_rom[10] = 9'b111000001;  // LI 1
    m_rom[11] = 9'b000001000;  // ADD R1,R0 -> R1=4
    m_rom[12] = 9'b111000011;  // LI 3
    m_rom[13] = 9'b111010001;  // CEQ R1
    m_rom[14] = 9'b111100110;  // BEQ R6 (not taken)
    m_rom[15] = HLT;
    begin_run();
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      model_step();
      n_cmp++;
      if (dut_state() !== model_state()) begin
        n_bad++;
        $display("FAIL br_cycle%0d: state %h, want %h", c, dut_state(), model_state());
      end
      if (c == 1 || c == 6) begin
        n_cmp++;
        if (dut.PC !== (c == 1 ? 8'd10 : 8'd15)) begin
          n_bad++;
          $display("FAIL br_target%0d: PC=%0d, want %0d", c, dut.PC, (c == 1 ? 10 : 15));
        end
      end
    end
  endtask

  task automatic test_wrap();
    fill_nop();
    randomize_state();
    begin_run();
    for (int c = 0; c < 258; c++) begin
      @(negedge CLK);
      model_step();
      n_cmp++;
      if (dut_state() !== model_state()) begin
        n_bad++;
        $display("FAIL wrap_cycle%0d: state %h, want %h", c, dut_state(), model_state());
      end
      if (c == 255) begin
        n_cmp++;
        if (dut.PC !== 8'd0) begin
          n_bad++;
          $display("FAIL wrap_pc: PC=%h after 256 fetches, want 00", dut.PC);
        end
      end
    end
  endtask

  task automatic test_async_start();
    fill_nop();
    randomize_state();
    m_rom[0] = 9'b111000101;  // LI 5
    m_rom[1] = 9'b111010000;  // CEQ R0 -> EQUAL=1
    m_rom[2] = HLT;
    begin_run();
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      model_step();
      n_cmp++;
      if (dut_state() !== model_state()) begin
        n_bad++;
        $display("FAIL async_cycle%0d: state %h, want %h", c, dut_state(), model_state());
      end
    end
    #2 start = 1'b1;
    #1;
    n_cmp++;
    if (halt !== 1'b0 || dut.PC !== 8'd0 || dut.EQUAL !== 1'b0 || dut.reg_file1.registers[0] !== 8'd5) begin
      n_bad++;
      $display("FAIL async_start: halt=%b PC=%h EQUAL=%b R0=%h, want 0 00 0 05",
               halt, dut.PC, dut.EQUAL, dut.reg_file1.registers[0]);
    end
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic test_random();
    int unsigned diffs;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) m_rom[i] = 9'($urandom_range(0, 511));
      randomize_state();
      begin_run();
      for (int c = 0; c < 150; c++) begin
        @(negedge CLK);
        model_step();
        n_cmp++;
        if (dut_state() !== model_state()) begin
          n_bad++;
          $display("FAIL rand%0d_cycle%0d: state %h, want %h", p, c, dut_state(), model_state());
        end
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (dut.data_mem1.core[i] !== m_mem[i]) diffs++;
      n_cmp++;
      if (diffs != 0) begin
        n_bad++;
        $display("FAIL rand%0d_mem: %0d bytes differ, want 0", p, diffs);
      end
    end
  endtask

  task automatic test_full_program();
    logic [10:0] msg [15];
    logic [7:0]  src [30];
    int unsigned diffs, cycles;
    fill_nop();
    randomize_state();
    for (int k = 0; k < 15; k++) begin
      msg[k]        = 11'($urandom);
      src[2*k]      = msg[k][7:0];
      src[2*k+1]    = {5'b0, msg[k][10:8]};
      m_mem[2*k]    = src[2*k];
      m_mem[2*k+1]  = src[2*k+1];
    end
    m_reg[1] = 8'd0; m_reg[2] = 8'd30; m_reg[3] = 8'd1;
    m_reg[4] = 8'd30; m_reg[6] = 8'd0; m_reg[7] = 8'd12;
    m_rom[0]  = 9'b101101001;  // LD R5,[R1]
    m_rom[1]  = 9'b000101101;  // ADD R5,R5
    m_rom[2]  = 9'b110101010;  // ST R5,[R2]
    m_rom[3]  = 9'b000001011;  // ADD R1,R3
    m_rom[4]  = 9'b000010011;  // ADD R2,R3
    m_rom[5]  = 9'b111000000;  // LI 0
    m_rom[6]  = 9'b000000100;  // ADD R0,R4
    m_rom[7]  = 9'b111010001;  // CEQ R1
    m_rom[8]  = 9'b111100111;  // BEQ R7
    m_rom[9]  = 9'b111000000;  // LI 0
    m_rom[10] = 9'b111010000;  // CEQ R0
    m_rom[11] = 9'b111100110;  // BEQ R6
    m_rom[12] = HLT;
    begin_run();
    cycles = 0;
    while (halt !== 1'b1 && cycles < 1500) begin
      @(negedge CLK);
      model_step();
      cycles++;
      n_cmp++;
      if (dut_state() !== model_state()) begin
        n_bad++;
        $display("FAIL full_cycle%0d: state %h, want %h", cycles, dut_state(), model_state());
      end
    end
    n_cmp++;
    if (halt !== 1'b1) begin
      n_bad++;
      $display("FAIL full_halt: halt=%b after %0d cycles, want 1", halt, cycles);
    end
    diffs = 0;
    for (int i = 0; i < 30; i++) begin
      if (dut.data_mem1.core[i] !== src[i]) diffs++;
      if (dut.data_mem1.core[30+i] !== 8'(src[i] << 1)) diffs++;
    end
    n_cmp++;
    if (diffs != 0) begin
      n_bad++;
      $display("FAIL full_bytes: %0d bytes wrong in 0..59, want 0", diffs);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b1;
    test_reset();
    test_alu();
    test_memory();
    test_branch();
    test_wrap();
    test_async_start();
    test_random();
    test_full_program();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
